mvb_rr_arbiter: RTL
===================

Name: mvb_rr_arbiter

Overview:
- Merges INPUTS independent MVB streams into one MVB output stream, which typically feeds a shared MVB FIFO.
- Arbitration is whole-word, round-robin, with a configurable burst length and a per-input enable mask.
- Output is registered, giving one word per cycle of throughput and a TX_SEL tag identifying the source input.

Parameters:
- INPUTS, 4: number of MVB requesters (>=2).
- REGIONS, 4: items per MVB word.
- ITEM_WIDTH, 32: bits per item.
- BURST, 1: maximum consecutive words granted to one input while others request (>=1).
- DEVICE, "ULTRASCALE": target device; passed through, no functional effect.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- CFG_EN  in  INPUTS  per-input enable; 0 = input never granted.
- RX_DATA  in  INPUTS*REGIONS*ITEM_WIDTH  input words; input i occupies slice i.
- RX_VLD  in  INPUTS*REGIONS  item valid per input/region.
- RX_SRC_RDY  in  INPUTS  word present.
- RX_DST_RDY  out  INPUTS  word accepted from input i.
- TX_DATA  out  REGIONS*ITEM_WIDTH  output word.
- TX_VLD  out  REGIONS  output item valid.
- TX_SRC_RDY  out  1  output word present.
- TX_DST_RDY  in  1  downstream ready.
- TX_SEL  out  log2(INPUTS)  source input index of the current TX word.

Behaviour:
- Transfer rules: an RX transfer on input i occurs when RX_SRC_RDY(i)=1 and RX_DST_RDY(i)=1; a TX transfer occurs when TX_SRC_RDY=1 and TX_DST_RDY=1.
- Request: req(i) = RX_SRC_RDY(i) and CFG_EN(i).
- State registers:
  - LAST: last granted input index.
  - CNT: consecutive grants to LAST, range 0..BURST.
  - Output register: TX_DATA, TX_VLD, TX_SRC_RDY, TX_SEL.
- Grant (combinational, same cycle):
  - If CNT<BURST and req(LAST)=1, grant LAST.
  - Otherwise grant the first requesting input found by cyclic search starting at LAST+1 (mod INPUTS), ending at LAST.
  - No requests means no grant.
- Output register load: can_load = not TX_SRC_RDY or TX_DST_RDY. RX_DST_RDY(g) = can_load for the granted g; all other RX_DST_RDY bits are 0.
- On an RX transfer from g:
  - If g==LAST, CNT<=min(CNT+1,BURST); otherwise LAST<=g and CNT<=1.
  - If any RX_VLD bit of g is 1: TX_DATA<=slice g, TX_VLD<=vld g, TX_SEL<=g, TX_SRC_RDY<=1.
  - If all VLD bits of g are 0: the word is consumed and dropped. It still counts as a grant. TX_SRC_RDY<=0 unless a held word remains (cannot happen, since can_load implies the held word was taken).
- No RX transfer while can_load=1: TX_SRC_RDY<=0.
- No RX transfer while can_load=0: the output register holds; TX_DATA/TX_VLD/TX_SEL stay stable while TX_SRC_RDY=1 and TX_DST_RDY=0.
- Latency: RX accept at edge k gives TX_SRC_RDY=1 from cycle k+1. Back-to-back throughput is 1 word/cycle.
- Fairness: with all inputs continuously requesting, the grant sequence is BURST words of 0, BURST words of 1, and so on, wrapping. A lone requester is granted every cycle regardless of BURST.
- CFG_EN changes act on the grant of the same cycle. A word already in the output register is unaffected. Clearing CFG_EN(LAST) mid-burst moves the grant to the next enabled requester.
- Reset, applied at any clock edge with RESET=1, including mid-burst or mid-stall:
  - TX_SRC_RDY<=0, TX_VLD<=0, TX_DATA<=0, TX_SEL<=0, LAST<=INPUTS-1, CNT<=BURST, so the first post-reset grant searches from input 0.
  - RX_DST_RDY=0 (combinationally forced) while RESET=1.
  - The held output word is discarded.
- Width rules: CNT width is log2(BURST+1) and saturates at BURST. The LAST+1 wrap is modulo INPUTS, including non-power-of-two INPUTS.

Decomposition:
- Shared package mvb_rr_arbiter_pkg holds:
  - the log2 function;
  - the SEL_WIDTH and CNT_WIDTH derivation functions;
  - a constant for the reset value of LAST.
- One sub-module, rr_grant_select: a combinational cyclic priority search.
  - Inputs: INPUTS-bit request vector, start index.
  - Outputs: grant one-hot, grant index, any_grant.
  - Instantiated once, with start = LAST or LAST+1 selected by the burst condition.

Test Plan (INPUTS=4, REGIONS=2, ITEM_WIDTH=8, BURST=2, TX_DST_RDY=1 unless stated):
- All inputs continuously ready, each with all VLD=11 and DATA=0xi0i1 -> TX_SEL sequence 0,0,1,1,2,2,3,3,0,...; first TX_SRC_RDY one cycle after reset release.
- Only input 2 ready for 5 words -> 5 consecutive TX words with TX_SEL=2, no bubbles; RX_DST_RDY(2)=1 every cycle.
- Input 1 sends a word with VLD=00 between two valid words -> RX_DST_RDY(1) pulses 3 times, TX shows 2 words; the burst pointer advances as if 3 grants occurred.
- TX_DST_RDY held 0 for 4 cycles with all inputs ready -> one word held stable in TX (TX_SEL, DATA unchanged); all RX_DST_RDY=0; no RX words lost after release.
- CFG_EN=1011 with all inputs ready -> input 2 never granted; sequence 0,0,1,1,3,3,0,...; setting CFG_EN(2)=1 mid-run makes it eligible at the next search.
- RESET asserted for 1 cycle mid-burst on input 1 with a word stalled in TX -> next cycle TX_SRC_RDY=0; after release the first grant is input 0 if input 0 is ready.

Source files
------------

// File: rtl/mvb_rr_arbiter_pkg.sv
// mvb_rr_arbiter_pkg
// Width derivations and reset constants shared by the MVB round-robin
// arbiter and its grant-search sub-module.
package mvb_rr_arbiter_pkg;

    // Ceiling log2; log2(1) = 0.
    function automatic int log2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Width of an input index (TX_SEL, LAST); never narrower than one bit.
    function automatic int sel_width(input int inputs);
        return (inputs > 1) ? log2(inputs) : 1;
    endfunction

    // Width of the burst counter, which must hold 0..burst.
    function automatic int cnt_width(input int burst);
        return (burst > 0) ? log2(burst + 1) : 1;
    endfunction

    // LAST resets to the highest index so the first search starts at input 0.
    function automatic int last_reset(input int inputs);
        return inputs - 1;
    endfunction

endpackage

// File: rtl/mvb_rr_arbiter_grant.sv
// rr_grant_select
// Combinational cyclic priority search: the first set bit of req found by
// scanning start, start+1, ... wrapping modulo INPUTS.
//   req        in   INPUTS  request vector
//   start      in   SEL_W   index examined first
//   gnt_onehot out  INPUTS  one-hot grant (all zero when no request)
//   gnt_idx    out  SEL_W   index of the granted input
//   any_gnt    out  1       at least one request present
module rr_grant_select #(
    parameter int INPUTS = 4,
    parameter int SEL_W  = 2
) (
    input  logic [INPUTS-1:0] req,
    input  logic [SEL_W-1:0]  start,
    output logic [INPUTS-1:0] gnt_onehot,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              any_gnt
);

    int idx;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any_gnt    = 1'b0;
        idx        = 0;
        for (int k = 0; k < INPUTS; k++) begin
            // Explicit wrap keeps non-power-of-two INPUTS correct.
            idx = int'(start) + k;
            if (idx >= INPUTS) begin
                idx = idx - INPUTS;
            end
            if (!any_gnt && req[idx]) begin
                any_gnt         = 1'b1;
                gnt_onehot[idx] = 1'b1;
                gnt_idx         = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mvb_rr_arbiter.sv
// mvb_rr_arbiter
// Merges INPUTS MVB streams into one registered MVB stream using whole-word
// round-robin arbitration with a burst limit and a per-input enable mask.
//   CLK, RESET   clock, synchronous active-high reset
//   CFG_EN       per-input enable (0 = never granted)
//   RX_DATA      INPUTS words, input i in slice i
//   RX_VLD       item valids per input/region
//   RX_SRC_RDY   word present per input
//   RX_DST_RDY   word accepted per input (only the granted input)
//   TX_DATA      registered output word
//   TX_VLD       registered output item valids
//   TX_SRC_RDY   output word present
//   TX_DST_RDY   downstream ready
//   TX_SEL       source input of the current output word
module mvb_rr_arbiter
    import mvb_rr_arbiter_pkg::*;
#(
    parameter int    INPUTS     = 4,
    parameter int    REGIONS    = 4,
    parameter int    ITEM_WIDTH = 32,
    parameter int    BURST      = 1,
    parameter string DEVICE     = "ULTRASCALE"
) (
    input  logic                                   CLK,
    input  logic                                   RESET,
    input  logic [INPUTS-1:0]                      CFG_EN,
    input  logic [INPUTS*REGIONS*ITEM_WIDTH-1:0]   RX_DATA,
    input  logic [INPUTS*REGIONS-1:0]              RX_VLD,
    input  logic [INPUTS-1:0]                      RX_SRC_RDY,
    output logic [INPUTS-1:0]                      RX_DST_RDY,
    output logic [REGIONS*ITEM_WIDTH-1:0]          TX_DATA,
    output logic [REGIONS-1:0]                     TX_VLD,
    output logic                                   TX_SRC_RDY,
    input  logic                                   TX_DST_RDY,
    output logic [sel_width(INPUTS)-1:0]           TX_SEL
);

    localparam int SEL_W  = sel_width(INPUTS);
    localparam int CNT_W  = cnt_width(BURST);
    localparam int WORD_W = REGIONS * ITEM_WIDTH;

    localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(last_reset(INPUTS));
    localparam logic [SEL_W-1:0] LAST_MAX = SEL_W'(INPUTS - 1);
    localparam logic [CNT_W-1:0] BURST_C  = CNT_W'(BURST);

    // DEVICE only selects vendor flavour elsewhere; it has no effect here.
    if (DEVICE == "") begin : g_no_device
    end

    logic [SEL_W-1:0]  last_sel;
    logic [CNT_W-1:0]  cnt;

    logic [INPUTS-1:0] req;
    logic              keep_last;
    logic [SEL_W-1:0]  next_sel;
    logic [SEL_W-1:0]  start_sel;
    logic [INPUTS-1:0] gnt_onehot;
    logic [SEL_W-1:0]  gnt_idx;
    logic              any_gnt;
    logic              can_load;
    logic              rx_xfer;

    logic [WORD_W-1:0]  sel_data;
    logic [REGIONS-1:0] sel_vld;

    logic [WORD_W-1:0]  tx_data_p1;
    logic [REGIONS-1:0] tx_vld_p1;
    logic [SEL_W-1:0]   tx_sel_p1;
    logic               vld_p1;

    assign req       = RX_SRC_RDY & CFG_EN;
    // Stay on LAST while its burst is unfinished and it still requests;
    // otherwise search from the input after LAST.
    assign keep_last = (cnt < BURST_C) && req[last_sel];
    assign next_sel  = (last_sel == LAST_MAX) ? '0 : last_sel + 1'b1;
    assign start_sel = keep_last ? last_sel : next_sel;

    rr_grant_select #(
        .INPUTS (INPUTS),
        .SEL_W  (SEL_W)
    ) u_grant (
        .req        (req),
        .start      (start_sel),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any_gnt    (any_gnt)
    );

    assign can_load   = !vld_p1 || TX_DST_RDY;
    assign rx_xfer    = any_gnt && can_load && !RESET;
    assign RX_DST_RDY = rx_xfer ? gnt_onehot : '0;

    always_comb begin
        sel_data = '0;
        sel_vld  = '0;
        for (int i = 0; i < INPUTS; i++) begin
            if (gnt_onehot[i]) begin
                sel_data = RX_DATA[i*WORD_W +: WORD_W];
                sel_vld  = RX_VLD[i*REGIONS +: REGIONS];
            end
        end
    end

    // ---- stage p1: output register and arbitration state ----
    always_ff @(posedge CLK) begin
        if (RESET) begin
            vld_p1     <= 1'b0;
            tx_vld_p1  <= '0;
            tx_data_p1 <= '0;
            tx_sel_p1  <= '0;
            last_sel   <= LAST_RST;
            cnt        <= BURST_C;
        end else begin
            if (rx_xfer) begin
                if (gnt_idx == last_sel) begin
                    if (cnt < BURST_C) begin
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    last_sel <= gnt_idx;
                    cnt      <= CNT_W'(1);
                end
                // An all-invalid word is consumed and dropped but still
                // counts as a grant above.
                if (|sel_vld) begin
                    tx_data_p1 <= sel_data;
                    tx_vld_p1  <= sel_vld;
                    tx_sel_p1  <= gnt_idx;
                    vld_p1     <= 1'b1;
                end else begin
                    vld_p1     <= 1'b0;
                end
            end else if (can_load) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign TX_DATA    = tx_data_p1;
    assign TX_VLD     = tx_vld_p1;
    assign TX_SEL     = tx_sel_p1;
    assign TX_SRC_RDY = vld_p1;

endmodule
